i2s_mic_rx: RTL and testbench
=============================

# i2s_mic_rx

I2S microphone receiver and DC-removal front end for the spectrogram path. Generates I2S bit clock and word select for a 24-bit MEMS microphone, deserialises the left-channel word, truncates it to 18 bits, and removes DC with a leaky-integrator high-pass. It emits one signed sample per frame as `ADATA0` with a single-cycle `ADATARDY` strobe, directly feeding the display/analysis stage's audio buffer.

## Interface
- `SCK_DIV`, 16: `CLK` cycles per SCK half-period. Must be even and ≥4.
- `DC_SHIFT`, 10: leak shift K of the DC tracker.
- `DC_EN`, 1: 1 enables DC removal. 0 outputs the truncated sample unchanged.

- `CLK` in 1: system clock (90 MHz); all logic on posedge.
- `nRST` in 1: synchronous, active-low reset.
- `I2S_SCK` out 1: bit clock = CLK/(2·SCK_DIV) (2.8125 MHz default).
- `I2S_WS` out 1: word select; 0 = left channel.
- `I2S_SD` in 1: serial data from the microphone.
- `ADATA0` out 18 signed: latest processed sample.
- `ADATARDY` out 1: one-cycle strobe; `ADATA0` is valid in the same cycle.
- `CLIP` out 1: one-cycle strobe, coincident with `ADATARDY`, when the output saturated.

## Operation
- **Phase counter `p`** runs 0..2·SCK_DIV−1. `I2S_SCK` is registered and equals 1 when p ≥ SCK_DIV.
- **Bit counter `b`** runs 0..63 and increments when p wraps. `I2S_WS` is registered and equals `b[5]`. WS therefore changes with the SCK falling edge.
- **SD capture**: `I2S_SD` is registered every CLK into `sd_q`. The data bit is taken from `sd_q` at p = SCK_DIV + SCK_DIV/2 (mid-high of SCK).
- **Left word** is captured MSB-first from b = 1 through b = 24 (24 bits) into a shift register. Bits b = 0 and b = 25..63 are ignored, which also ignores the entire right channel.
- **Pipeline** starts at the sampling cycle of b = 24 (stage S0):
  - S1: x = shift[23:6], an 18-bit signed truncation (arithmetic, no rounding).
  - S2: dc = acc >>> DC_SHIFT, using acc before update. y = x − dc, computed at 20 bits. acc ← acc + x − dc. acc is signed, 18+DC_SHIFT+2 bits, and never overflows for in-range x. With DC_EN = 0, y = x and acc holds 0.
  - S3: y is saturated to [−131072, 131071] and registered into `ADATA0`. `ADATARDY` = 1. `CLIP` = 1 if saturation occurred.
- There is no backpressure. The consumer must accept each strobe; strobes are never back-to-back.
- **Reset**: p, b, shift, acc, pipeline valids, `I2S_SCK`, `I2S_WS`, `ADATA0`, `ADATARDY`, `CLIP` all go to 0. `ADATA0` holds its value between strobes.
- **Reset mid-frame**: the partial word and any in-flight pipeline stage are discarded, and no strobe is produced for that frame. The first cycle with nRST high is p = 0, b = 0.
- **Simultaneous events**: a new frame's capture can never overlap the pipeline, since the pipeline is 3 cycles and the frame is 2048 cycles. No arbitration is required.

## Timing
- Frame = 64·2·SCK_DIV = 2048 CLK (43.945 kHz at 90 MHz). Exactly one `ADATARDY` per frame.
- With cycle 0 = first cycle after reset release:
  - the LSB is sampled at cycle 24·2·SCK_DIV + 1.5·SCK_DIV = 792 (default);
  - `ADATARDY` is asserted at cycle 795, then every 2048 cycles.
- `I2S_SCK` first rises at cycle SCK_DIV (16). `I2S_WS` first rises at cycle 32·2·SCK_DIV (1024).
- Latency from LSB sample to strobe: 3 CLK, fixed.

## Test plan
1. **Reset**: hold nRST low 5 cycles mid-frame.
   - Required: all outputs 0 during reset.
   - Required after release: SCK rises at cycle 16, WS rises at cycle 1024, first `ADATARDY` at cycle 795.
2. **Frame timing**: run 10 frames.
   - Required: `ADATARDY` period is exactly 2048 cycles and 1 cycle wide.
   - Required: WS period 2048 with 50% duty; SCK period 32.
3. **Bypass (DC_EN = 0)**: mic model drives left 0x123456 and right 0xFFFFFF.
   - Required: `ADATA0` = 18641 (0x048D1) and `CLIP` = 0.
   - Required: left 0x800000 gives `ADATA0` = −131072.
4. **DC removal (DC_EN = 1, K = 10)**: constant left word giving x = 1000.
   - Required: first output is 1000, and outputs decrease monotonically.
   - Required: `ADATA0` = 0 within 20000 frames.
5. **Saturation**: with acc settled at dc = −131072, step x to +131071.
   - Required: `ADATA0` = 131071 and `CLIP` pulses once.
6. **Reset mid-word**: assert nRST for 1 cycle at b = 10 of the left word.
   - Required: no strobe for that frame.
   - Required: the next strobe comes at cycle 795 after release with correct data and acc = 0.

Source files
------------

// File: rtl/i2s_mic_rx_if.sv
// I2S microphone pins plus the processed-sample output of the receiver.
// The receiver uses the master modport; a microphone model or consumer uses the slave modport.
interface i2s_mic_rx_if;
  logic               i2s_sck;
  logic               i2s_ws;
  logic               i2s_sd;
  logic signed [17:0] adata0;
  logic               adatardy;
  logic               clip;

  modport master (
    output i2s_sck,
    output i2s_ws,
    output adata0,
    output adatardy,
    output clip,
    input  i2s_sd
  );

  modport slave (
    input  i2s_sck,
    input  i2s_ws,
    input  adata0,
    input  adatardy,
    input  clip,
    output i2s_sd
  );
endinterface

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a 24-bit MEMS mic: takes the left word, truncates it to 18 bits,
// removes DC with a leaky integrator and emits one saturated sample per frame.
module i2s_mic_rx #(
  parameter int SCK_DIV  = 16,
  parameter int DC_SHIFT = 10,
  parameter bit DC_EN    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  i2s_mic_rx_if.master     io_bus
);

  localparam int PW = $clog2(2 * SCK_DIV);
  localparam int AW = 18 + DC_SHIFT + 2;
  localparam logic [PW-1:0] P_LAST = PW'(2 * SCK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(SCK_DIV);
  localparam logic [PW-1:0] P_SAMP = PW'(SCK_DIV + SCK_DIV / 2);
  localparam logic signed [AW-1:0] SAT_MAX = AW'(131071);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-131072);

  logic [PW-1:0]         r_p;
  logic [5:0]            r_b;
  logic                  r_sck;
  logic                  r_ws;
  logic                  r_sd_q;
  logic [23:0]           r_shift;
  logic                  r_v0;
  logic                  r_v1;
  logic signed [AW-1:0]  r_x;
  logic signed [AW-1:0]  r_acc;
  logic signed [17:0]    r_adata;
  logic                  r_rdy;
  logic                  r_clip;

  logic [PW-1:0]         w_p_nxt;
  logic [5:0]            w_b_nxt;
  logic                  w_wrap;
  logic                  w_samp;
  logic                  w_left_bit;
  logic signed [AW-1:0]  w_dc;
  logic signed [AW-1:0]  w_y;
  logic signed [AW-1:0]  w_acc_nxt;
  logic                  w_hi;
  logic                  w_lo;
  logic signed [17:0]    w_sat;

  always_comb begin
    w_wrap     = (r_p == P_LAST);
    w_p_nxt    = w_wrap ? '0 : r_p + PW'(1);
    w_b_nxt    = w_wrap ? r_b + 6'd1 : r_b;
    w_samp     = (r_p == P_SAMP);
    w_left_bit = (r_b >= 6'd1) && (r_b <= 6'd24);
    // dc uses the accumulator value from before this sample's update
    w_dc       = r_acc >>> DC_SHIFT;
    w_y        = DC_EN ? (r_x - w_dc) : r_x;
    w_acc_nxt  = r_acc + w_y;
    w_hi       = (w_y > SAT_MAX);
    w_lo       = (w_y < SAT_MIN);
    if (w_hi)
      w_sat = 18'sh1FFFF;
    else if (w_lo)
      w_sat = 18'sh20000;
    else
      w_sat = w_y[17:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_p     <= '0;
      r_b     <= '0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_sd_q  <= 1'b0;
      r_shift <= '0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_x     <= '0;
      r_acc   <= '0;
      r_adata <= '0;
      r_rdy   <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_sd_q <= io_bus.i2s_sd;
      r_p    <= w_p_nxt;
      r_b    <= w_b_nxt;
      // SCK and WS are registered from the next counter values so they line up with p and b
      r_sck  <= (w_p_nxt >= P_HALF);
      r_ws   <= w_b_nxt[5];

      r_v0 <= 1'b0;
      if (w_samp && w_left_bit) begin
        r_shift <= {r_shift[22:0], r_sd_q};
        r_v0    <= (r_b == 6'd24);
      end

      r_v1 <= r_v0;
      if (r_v0)
        r_x <= AW'($signed(r_shift) >>> 6);

      r_rdy  <= r_v1;
      r_clip <= r_v1 && (w_hi || w_lo);
      if (r_v1) begin
        r_adata <= w_sat;
        r_acc   <= DC_EN ? w_acc_nxt : '0;
      end
    end
  end

  assign io_bus.i2s_sck  = r_sck;
  assign io_bus.i2s_ws   = r_ws;
  assign io_bus.adata0   = r_adata;
  assign io_bus.adatardy = r_rdy;
  assign io_bus.clip     = r_clip;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: two instances (default bypass, and a fast DC-removal variant) driven
// by a frame-level microphone model, checked every cycle plus literal spot checks.
module tb_i2s_mic_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst_a = 1'b0;
  logic nrst_b = 1'b0;

  i2s_mic_rx_if if_a ();
  i2s_mic_rx_if if_b ();

  i2s_mic_rx #(.SCK_DIV(16), .DC_SHIFT(10), .DC_EN(1'b0)) u_dut_a (
    .i_clk  (clk),
    .i_nrst (nrst_a),
    .io_bus (if_a.master)
  );

  i2s_mic_rx #(.SCK_DIV(4), .DC_SHIFT(2), .DC_EN(1'b1)) u_dut_b (
    .i_clk  (clk),
    .i_nrst (nrst_b),
    .io_bus (if_b.master)
  );

  int errors = 0;
  int checks = 0;

  int          k         [2] = '{0, 0};
  logic [23:0] pend_left [2] = '{24'h0, 24'h0};
  logic [23:0] cur_left  [2] = '{24'h0, 24'h0};
  logic [23:0] cur_right [2] = '{24'h0, 24'h0};
  longint      acc       [2] = '{0, 0};
  longint      exp_adata [2] = '{0, 0};
  bit          exp_rdy   [2] = '{0, 0};
  bit          exp_clip  [2] = '{0, 0};
  bit          exp_sck   [2] = '{0, 0};
  bit          exp_ws    [2] = '{0, 0};

  function automatic int sdiv(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic int kshift(input int d);
    return (d == 0) ? 10 : 2;
  endfunction

  function automatic bit den(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  // LSB of the left word is sampled at 24 SCK periods + 1.5 half-periods; strobe 3 cycles later
  function automatic int rdy_off(input int d);
    return 48 * sdiv(d) + (3 * sdiv(d)) / 2 + 3;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Microphone and reference model: one step per clock, frame arithmetic from cycle count
  initial begin : drv
    int S;
    int F;
    int b;
    bit rs;
    bit sdv;
    int lv;
    longint x;
    longint dc;
    longint y;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        rs = (d == 0) ? nrst_a : nrst_b;
        S  = sdiv(d);
        F  = 128 * S;
        if (!rs) begin
          k[d] = 0;
          acc[d] = 0;
          exp_adata[d] = 0;
        end else begin
          k[d] = k[d] + 1;
        end
        if (k[d] % F == 0) begin
          cur_left[d]  = pend_left[d];
          cur_right[d] = (d == 0) ? 24'hFFFFFF : 24'($urandom);
        end
        b = (k[d] / (2 * S)) % 64;
        if (b >= 1 && b <= 24)
          sdv = cur_left[d][24 - b];
        else if (b >= 33 && b <= 56)
          sdv = cur_right[d][56 - b];
        else
          sdv = 1'($urandom);
        if (d == 0) if_a.i2s_sd = sdv;
        else        if_b.i2s_sd = sdv;
        exp_sck[d]  = ((k[d] % (2 * S)) >= S);
        exp_ws[d]   = (b >= 32);
        exp_rdy[d]  = 1'b0;
        exp_clip[d] = 1'b0;
        if (k[d] % F == rdy_off(d)) begin
          lv = {{8{cur_left[d][23]}}, cur_left[d]};
          x  = lv >>> 6;
          dc = den(d) ? (acc[d] >>> kshift(d)) : 0;
          y  = x - dc;
          exp_rdy[d]  = 1'b1;
          exp_clip[d] = (y > 131071) || (y < -131072);
          exp_adata[d] = (y > 131071) ? 131071 : ((y < -131072) ? -131072 : y);
          if (den(d)) acc[d] = acc[d] + y;
        end
      end
    end
  end

  initial begin : cmp_proc
    longint ga;
    bit gs;
    bit gw;
    bit gr;
    bit gc;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          gs = if_a.i2s_sck; gw = if_a.i2s_ws; gr = if_a.adatardy; gc = if_a.clip; ga = if_a.adata0;
        end else begin
          gs = if_b.i2s_sck; gw = if_b.i2s_ws; gr = if_b.adatardy; gc = if_b.clip; ga = if_b.adata0;
        end
        check(d == 0 ? "a.sck" : "b.sck", gs, exp_sck[d]);
        check(d == 0 ? "a.ws" : "b.ws", gw, exp_ws[d]);
        check(d == 0 ? "a.rdy" : "b.rdy", gr, exp_rdy[d]);
        check(d == 0 ? "a.clip" : "b.clip", gc, exp_clip[d]);
        check(d == 0 ? "a.adata" : "b.adata", ga, exp_adata[d]);
      end
    end
  end

  task automatic wait_rdy_b(output bit ok, output longint v, output bit cl);
    ok = 1'b0;
    v  = 0;
    cl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (if_b.adatardy) begin
        ok = 1'b1;
        v  = if_b.adata0;
        cl = if_b.clip;
        break;
      end
    end
    check("b.rdy_timeout", ok, 1);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int first_sck;
    int first_ws;
    int last_rdy;
    int nrdy;
    int ws_hi;
    int sck_rise;
    bit prev_sck;
    bit prev_rdy;
    bit ok;
    bit cl;
    bit zero;
    longint v;
    longint prev;

    pend_left[0] = 24'h123456;
    pend_left[1] = 24'(1000 * 64 + 37);

    fork
      begin : thread_a
        repeat (5) @(negedge clk);
        nrst_a = 1'b1;
        repeat (1000) @(negedge clk);
        check("a.bypass_first", if_a.adata0, 18641);
        nrst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("a.rst_sck", if_a.i2s_sck, 0);
          check("a.rst_ws", if_a.i2s_ws, 0);
          check("a.rst_rdy", if_a.adatardy, 0);
          check("a.rst_clip", if_a.clip, 0);
          check("a.rst_adata", if_a.adata0, 0);
        end
        nrst_a = 1'b1;
        first_sck = -1; first_ws = -1; last_rdy = -1;
        nrdy = 0; ws_hi = 0; sck_rise = 0; prev_sck = 1'b0; prev_rdy = 1'b0;
        for (int c = 0; c < 11 * 2048; c++) begin
          if (c > 0) @(negedge clk);
          if (if_a.i2s_sck && !prev_sck) begin
            if (first_sck < 0) first_sck = c;
            if (c < 10 * 2048) sck_rise++;
          end
          if (if_a.i2s_ws && first_ws < 0) first_ws = c;
          if (c < 10 * 2048 && if_a.i2s_ws) ws_hi++;
          if (prev_rdy) check("a.rdy_width", if_a.adatardy, 0);
          if (if_a.adatardy) begin
            if (last_rdy < 0) check("a.first_rdy", c, 795);
            else              check("a.rdy_period", c - last_rdy, 2048);
            last_rdy = c;
            nrdy++;
            check("a.bypass_data", if_a.adata0, (c / 2048 >= 5) ? -131072 : 18641);
            check("a.bypass_clip", if_a.clip, 0);
          end
          if (c == 4 * 2048 + 1000) pend_left[0] = 24'h800000;
          prev_sck = if_a.i2s_sck;
          prev_rdy = if_a.adatardy;
        end
        check("a.first_sck_rise", first_sck, 16);
        check("a.first_ws_rise", first_ws, 1024);
        check("a.rdy_count", nrdy, 11);
        check("a.sck_rises_10f", sck_rise, 640);
        check("a.ws_high_10f", ws_hi, 10240);
        // reset pulse at b = 10 of the left word
        repeat (331) @(negedge clk);
        nrst_a = 1'b0;
        @(negedge clk);
        nrst_a = 1'b1;
        for (int c = 0; c < 800; c++) begin
          if (c > 0) @(negedge clk);
          check("a.midword_rdy", if_a.adatardy, (c == 795) ? 1 : 0);
          if (c == 795) check("a.midword_data", if_a.adata0, -131072);
        end
      end

      begin : thread_b
        repeat (3) @(negedge clk);
        nrst_b = 1'b1;
        zero = 1'b0;
        prev = 0;
        for (int f = 0; f < 60; f++) begin
          wait_rdy_b(ok, v, cl);
          if (!ok) break;
          if (f == 0) check("b.dc_first", v, 1000);
          else        check("b.dc_monotone", (v <= prev) ? 1 : 0, 1);
          prev = v;
          if (v == 0) begin
            zero = 1'b1;
            break;
          end
        end
        check("b.dc_reaches_zero", zero, 1);

        pend_left[1] = 24'h800000;
        zero = 1'b0;
        for (int f = 0; f < 150; f++) begin
          wait_rdy_b(ok, v, cl);
          if (!ok) break;
          if (v == 0) begin
            zero = 1'b1;
            break;
          end
        end
        check("b.settle_neg_fs", zero, 1);

        pend_left[1] = 24'h7FFFFF;
        wait_rdy_b(ok, v, cl);
        check("b.sat_data", v, 131071);
        check("b.sat_clip", cl, 1);
        @(negedge clk);
        check("b.clip_width", if_b.clip, 0);

        pend_left[1] = 24'(-319963);
        wait_rdy_b(ok, v, cl);
        for (int i = 0; i < 600 && (k[1] % 512) != 82; i++) @(negedge clk);
        check("b.midword_pos", k[1] % 512, 82);
        nrst_b = 1'b0;
        @(negedge clk);
        nrst_b = 1'b1;
        for (int c = 0; c < 210; c++) begin
          if (c > 0) @(negedge clk);
          check("b.midword_rdy", if_b.adatardy, (c == 201) ? 1 : 0);
          if (c == 201) check("b.midword_data_acc0", if_b.adata0, -5000);
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
